boot_image_loader: RTL and testbench
====================================

// Module: boot_image_loader
// PURPOSE
//  Synthesizable program-image writer for NF5 bring-up. Accepts a byte stream (valid/ready) from a host link,
//  packs the bytes little-endian into 32-bit words and writes them into the core's data/instruction memory
//  starting at word 0. The byte-to-word mapping is byte k -> word k/4, bits [8*(k%4)+:8].
//  Holds the core in reset until the image is complete, then releases it.
// PARAMETERS
//  ADDR_W       12    word-address width of the target memory
//  DEPTH_WORDS  4096  number of writable words; a write at index >= DEPTH_WORDS is an overflow
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       one-cycle pulse: begin a new load (ignored while busy)
//  in_valid     in   1       byte available on in_data
//  in_data      in   8       image byte
//  in_last      in   1       qualifies the final byte of the image (sampled with in_valid & in_ready)
//  in_ready     out  1       loader accepts a byte this cycle
//  mem_we       out  1       one-cycle memory write strobe
//  mem_addr     out  ADDR_W  word address of the write
//  mem_wdata    out  32      packed word
//  mem_be       out  4       byte enables for the write
//  core_rst_n   out  1       active-low reset to Core; 0 = core held in reset
//  busy         out  1       load in progress (LOAD or FLUSH)
//  done         out  1       image loaded, core released
//  err_overflow out  1       image exceeded DEPTH_WORDS
//  word_count   out  ADDR_W+1  words written in the current load
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; in_ready, mem_we, mem_be, busy, done, err_overflow = 0;
//    mem_addr, mem_wdata, word_count = 0; core_rst_n = 0; byte-lane counter and assembly register cleared.
//  States: IDLE, LOAD, FLUSH, DONE, ERR.
//  IDLE : core_rst_n=0, in_ready=0. start -> LOAD; clears word_count, lane, assembly register.
//  LOAD : busy=1, in_ready=1. Each accepted byte (in_valid&in_ready) goes into lane 0..3.
//    Lane 3 accepted  -> next cycle mem_we=1, mem_be=4'hF, mem_addr=word_count, mem_wdata=packed word;
//                        word_count increments in that same cycle; lane wraps to 0.
//    No stall on a full word: a byte can be accepted in the same cycle mem_we is high.
//    in_last on lane 3 -> LOAD->DONE after that write; in_last on lane 0..2 -> FLUSH.
//    Overflow: accepting a byte whose word index >= DEPTH_WORDS -> ERR; the byte is dropped and no write issued.
//  FLUSH: one cycle. mem_we=1, partial word; unwritten upper bytes=0; mem_be = low lanes received
//    (1 byte 4'b0001, 2 bytes 4'b0011, 3 bytes 4'b0111). Then -> DONE.
//  DONE : entered the cycle after the final mem_we; done=1, core_rst_n=1, in_ready=0. start -> LOAD,
//    which drops core_rst_n to 0 and clears done in that cycle.
//  ERR  : err_overflow=1, core_rst_n=0, in_ready=0. start -> LOAD (clears err_overflow).
//  start while busy: ignored. in_valid while in_ready=0: not consumed; the byte must be held by the source.
//  mem_we is never high for two words at the same address within one load; mem_addr == word_count at each write.
//  word_count saturates only by overflow detection and never exceeds DEPTH_WORDS.
//  Reset mid-load: any pending write is cancelled and core_rst_n=0 immediately; state returns to IDLE.
// TESTING
//  1 start; bytes 13 00 00 00 93 00 10 00 (last on 8th) -> addr0=0x00000013 be F, addr1=0x00100093 be F;
//    done=1 and core_rst_n=1 one cycle after the 2nd mem_we; word_count=2.
//  2 five bytes 13 00 00 00 AB (last) -> addr1 wdata=0x000000AB, be=4'b0001 via FLUSH; word_count=2.
//  3 test 1 with random in_valid gaps -> identical write sequence; no mem_we without 4 bytes or a last.
//  4 DEPTH_WORDS=2, 9 bytes -> exactly 2 writes, err_overflow=1, in_ready=0, core_rst_n stays 0.
//  5 rst asserted after 6 bytes -> all outputs zero in the same cycle; no further mem_we; restart loads cleanly.
//  6 start in DONE -> core_rst_n falls, new image overwrites from addr0; start pulse during LOAD ignored.

Source files
------------

// File: rtl/boot_image_loader_if.sv
// Byte-stream intake and word-write memory bus of the boot image loader.
// The slave side is the loader; the master side is the host/memory harness.
interface boot_image_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/boot_image_loader.sv
// Packs a little-endian byte stream into 32-bit words, writes them from
// word 0 upward, and holds the core in reset until the image is complete.
module boot_image_loader #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  boot_image_loader_if.slave bus,
  input  logic              start,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, FLUSH, DONE, ERR
  } state_t;

  state_t      state;
  logic [1:0]  lane;
  logic [23:0] asm_q;
  logic        accept;
  logic        ovf;
  logic [31:0] pack_w;
  logic [3:0]  be_w;

  assign accept = bus.in_valid & bus.in_ready;
  assign ovf = word_count >= (ADDR_W+1)'(DEPTH_WORDS);

  // Upper lanes not yet received are forced to zero.
  always_comb begin
    pack_w = {bus.in_data, asm_q};
    be_w   = 4'hF;
    case (lane)
      2'd0: begin
        pack_w = {24'h0, bus.in_data};
        be_w   = 4'b0001;
      end
      2'd1: begin
        pack_w = {16'h0, bus.in_data, asm_q[7:0]};
        be_w   = 4'b0011;
      end
      2'd2: begin
        pack_w = {8'h0, bus.in_data, asm_q[15:0]};
        be_w   = 4'b0111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lane          <= 2'd0;
      asm_q         <= 24'h0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'h0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
      core_rst_n    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_overflow  <= 1'b0;
      word_count    <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.mem_be <= 4'h0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            core_rst_n   <= 1'b0;
            word_count   <= '0;
            lane         <= 2'd0;
            asm_q        <= 24'h0;
          end
        end
        LOAD: begin
          if (accept && ovf) begin
            state        <= ERR;
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
            err_overflow <= 1'b1;
          end else if (accept) begin
            if (lane == 2'd3 || bus.in_last) begin
              bus.mem_we    <= 1'b1;
              bus.mem_be    <= be_w;
              bus.mem_addr  <= word_count[ADDR_W-1:0];
              bus.mem_wdata <= pack_w;
              word_count    <= word_count + 1'b1;
              lane          <= 2'd0;
              asm_q         <= 24'h0;
            end else begin
              lane <= lane + 2'd1;
              case (lane)
                2'd0:    asm_q[7:0]   <= bus.in_data;
                2'd1:    asm_q[15:8]  <= bus.in_data;
                default: asm_q[23:16] <= bus.in_data;
              endcase
            end
            // FLUSH is the cycle the final write is on the bus.
            if (bus.in_last) begin
              state        <= FLUSH;
              bus.in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state      <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          core_rst_n <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_image_loader.sv
// Randomized bench for boot_image_loader against a queue-based image model.
// A second instance with a two-word memory exercises overflow.
module tb_boot_image_loader;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic       in_valid;
  logic       in_last;
  logic [7:0] in_data;

  logic        cr_a, busy_a, done_a, err_a;
  logic        cr_b, busy_b, done_b, err_b;
  logic [12:0] wc_a, wc_b;

  boot_image_loader_if #(.ADDR_W(12)) ifa ();
  boot_image_loader_if #(.ADDR_W(12)) ifb ();

  assign ifa.in_valid = in_valid;
  assign ifa.in_data  = in_data;
  assign ifa.in_last  = in_last;
  assign ifb.in_valid = in_valid;
  assign ifb.in_data  = in_data;
  assign ifb.in_last  = in_last;

  boot_image_loader u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (ifa.slave),
    .start        (start & ~sel),
    .core_rst_n   (cr_a),
    .busy         (busy_a),
    .done         (done_a),
    .err_overflow (err_a),
    .word_count   (wc_a)
  );

  boot_image_loader #(.ADDR_W(12), .DEPTH_WORDS(2)) u_ovf (
    .clk          (clk),
    .rst          (rst),
    .bus          (ifb.slave),
    .start        (start & sel),
    .core_rst_n   (cr_b),
    .busy         (busy_b),
    .done         (done_b),
    .err_overflow (err_b),
    .word_count   (wc_b)
  );

  logic        o_ready, o_we, o_cr, o_busy, o_done, o_err;
  logic [11:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_be;
  logic [12:0] o_wc;

  assign o_ready = sel ? ifb.in_ready  : ifa.in_ready;
  assign o_we    = sel ? ifb.mem_we    : ifa.mem_we;
  assign o_addr  = sel ? ifb.mem_addr  : ifa.mem_addr;
  assign o_wdata = sel ? ifb.mem_wdata : ifa.mem_wdata;
  assign o_be    = sel ? ifb.mem_be    : ifa.mem_be;
  assign o_cr    = sel ? cr_b   : cr_a;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_err   = sel ? err_b  : err_a;
  assign o_wc    = sel ? wc_b   : wc_a;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = -1;

  logic [11:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_be[$];
  logic [11:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_be[$];
  logic        exp_err;
  int          exp_wc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_we) begin
      log_addr.push_back(o_addr);
      log_data.push_back(o_wdata);
      log_be.push_back(o_be);
      last_we_cyc = cyc;
    end
    if (o_done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Byte k lands in word k/4, lane k%4; anything past the memory is lost.
  task automatic model(input bq_t img, input int depth);
    int n, acc;
    logic [31:0] d;
    logic [3:0]  be;
    exp_addr.delete();
    exp_data.delete();
    exp_be.delete();
    n = img.size();
    acc = (n > 4 * depth) ? 4 * depth : n;
    exp_err = (n > 4 * depth);
    exp_wc = 0;
    for (int w = 0; w * 4 < acc; w++) begin
      d = 32'h0;
      be = 4'h0;
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < acc) begin
          d = d | (32'(img[w*4+b]) << (8 * b));
          be[b] = 1'b1;
        end
      end
      exp_addr.push_back(12'(w));
      exp_data.push_back(d);
      exp_be.push_back(be);
      exp_wc++;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_be.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input bq_t img, input int gap, input int mid_start,
                      input bit with_last);
    int t;
    for (int i = 0; i < img.size(); i++) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = img[i];
      in_last  = with_last && (i == img.size() - 1);
      t = 0;
      while (!o_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!o_ready) begin
        chk("ready_timeout", 64'(exp_err), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        break;
      end
      start = (i == mid_start);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic run(input bq_t img, input int gap, input int mid_start,
                     input int depth, input bit do_start);
    int t;
    model(img, depth);
    if (do_start) pulse_start();
    clear_log();
    done_cyc = -1;
    send(img, gap, mid_start, 1'b1);
    t = 0;
    while (!(o_done || o_err) && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!(o_done || o_err)) chk("end_timeout", 64'(o_done | o_err), 64'd1);
    @(negedge clk);
    chk("n_writes", 64'(log_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      chk($sformatf("addr%0d", i), 64'(log_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("data%0d", i), 64'(log_data[i]), 64'(exp_data[i]));
      chk($sformatf("be%0d", i), 64'(log_be[i]), 64'(exp_be[i]));
    end
    chk("err_overflow", 64'(o_err), 64'(exp_err));
    chk("done", 64'(o_done), 64'(!exp_err));
    chk("core_rst_n", 64'(o_cr), 64'(!exp_err));
    chk("word_count", 64'(o_wc), 64'(exp_wc));
    chk("in_ready_end", 64'(o_ready), 64'd0);
    chk("busy_end", 64'(o_busy), 64'd0);
    if (!exp_err)
      chk("done_latency", 64'(done_cyc - last_we_cyc), 64'd1);
  endtask

  function automatic bq_t rand_img(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    bq_t img1, img2, img9, q;
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bq_t img1, img2, img9, q;
    img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    img2 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hAB};
    img9 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    rst = 1'b1;
    start = 1'b0;
    sel = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_core_rst_n", 64'(o_cr), 64'd0);
    chk("rst_in_ready", 64'(o_ready), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_wc", 64'(o_wc), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(o_ready), 64'd0);

    run(img1, 0, -1, 4096, 1'b1);
    run(img2, 0, -1, 4096, 1'b1);
    run(img1, 3, -1, 4096, 1'b1);

    // Restart from DONE releases and re-grabs the core.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_core_rst_n", 64'(o_cr), 64'd0);
    chk("restart_done", 64'(o_done), 64'd0);
    chk("restart_busy", 64'(o_busy), 64'd1);
    run(img2, 1, 2, 4096, 1'b0);

    for (int k = 0; k < 8; k++) begin
      q = rand_img($urandom_range(1, 40));
      run(q, $urandom_range(0, 3),
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, q.size() - 1)) : -1,
          4096, 1'b1);
    end

    // Asynchronous reset lands while a full-word write is on the bus.
    pulse_start();
    clear_log();
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(q, 0, -1, 1'b0);
    chk("we_before_rst", 64'(o_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_we", 64'(o_we), 64'd0);
    chk("arst_core_rst_n", 64'(o_cr), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_ready", 64'(o_ready), 64'd0);
    chk("arst_wc", 64'(o_wc), 64'd0);
    chk("arst_addr", 64'(o_addr), 64'd0);
    chk("arst_wdata", 64'(o_wdata), 64'd0);
    clear_log();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("writes_after_rst", 64'(log_addr.size()), 64'd0);
    run(img1, 2, -1, 4096, 1'b1);

    sel = 1'b1;
    @(negedge clk);
    run(img9, 0, -1, 2, 1'b1);
    chk("ovf_ready", 64'(o_ready), 64'd0);
    for (int k = 0; k < 6; k++) begin
      q = rand_img($urandom_range(1, 14));
      run(q, $urandom_range(0, 2), -1, 2, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
